// File: rtl/mem_bus_master.sv
// mem_bus_master: single-byte initiator for the async-read / clocked-write RAM bus.
// Optional write read-back verify is enabled by defining MEMBUS_WRITE_VERIFY_EN.
//
// state    | meaning
// S_IDLE   | strobes high, bus released, waiting for req
// S_SETUP  | address (and write data) presented, strobes still high
// S_ACCESS | cs_ low with oe_ (read) or we_ (write) low for 1+WaitStates cycles
// S_TURN   | write-verify only: bus released, cs_ high for one cycle
// S_VREAD  | write-verify only: read back the written byte for 1+WaitStates cycles
// S_HOLD   | strobes high, write data held, ack pulsed
module mem_bus_master #(
    parameter int WaitStates = 0,
    parameter int CntWidth   = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic        cs_,
    output logic        oe_,
    output logic        we_,
    output logic [15:0] addr,
    inout  wire  [7:0]  data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_TURN,
        S_VREAD,
        S_HOLD
    } state_t;

    localparam logic [CntWidth-1:0] WaitLd = CntWidth'(WaitStates);

    state_t                state, state_n;
    logic [CntWidth-1:0]   cnt, cnt_n;
    logic                  wr_q, wr_n;
    logic [7:0]            wdata_q, wdata_n;
    logic [15:0]           addr_n;
    logic [7:0]            rdata_n;
    logic                  wr_drive, drive_n;
    logic                  cs_n, oe_n, we_n, ack_n, busy_n;

`ifdef MEMBUS_WRITE_VERIFY_EN
    logic                  err_q, err_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = wr_q;
        wdata_n = wdata_q;
        addr_n  = addr;
        rdata_n = rdata;
`ifdef MEMBUS_WRITE_VERIFY_EN
        err_n   = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_n = S_SETUP;
                    wr_n    = wr;
                    wdata_n = wdata;
                    addr_n  = req_addr;
`ifdef MEMBUS_WRITE_VERIFY_EN
                    err_n   = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                state_n = S_ACCESS;
                cnt_n   = WaitLd;
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    if (!wr_q) rdata_n = data;
`ifdef MEMBUS_WRITE_VERIFY_EN
                    state_n = wr_q ? S_TURN : S_HOLD;
`else
                    state_n = S_HOLD;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef MEMBUS_WRITE_VERIFY_EN
            S_TURN: begin
                state_n = S_VREAD;
                cnt_n   = WaitLd;
            end
            S_VREAD: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    err_n   = (data != wdata_q);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            S_HOLD:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered.
        cs_n    = !(state_n == S_ACCESS || state_n == S_VREAD);
        oe_n    = !((state_n == S_ACCESS && !wr_n) || state_n == S_VREAD);
        we_n    = !(state_n == S_ACCESS && wr_n);
        // Hold-time drive in HOLD only when coming straight from the write strobe.
        drive_n = wr_n && (state_n == S_SETUP || state_n == S_ACCESS ||
                           (state_n == S_HOLD && state == S_ACCESS));
        ack_n   = (state_n == S_HOLD);
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= 8'h00;
            addr     <= 16'h0000;
            rdata    <= 8'h00;
            ack      <= 1'b0;
            busy     <= 1'b0;
            cs_      <= 1'b1;
            oe_      <= 1'b1;
            we_      <= 1'b1;
            wr_drive <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wr_q     <= wr_n;
            wdata_q  <= wdata_n;
            addr     <= addr_n;
            rdata    <= rdata_n;
            ack      <= ack_n;
            busy     <= busy_n;
            cs_      <= cs_n;
            oe_      <= oe_n;
            we_      <= we_n;
            wr_drive <= drive_n;
        end
    end

`ifdef MEMBUS_WRITE_VERIFY_EN
    always_ff @(posedge clk) begin
        if (!rst_) err_q <= 1'b0;
        else       err_q <= err_n;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign data = wr_drive ? wdata_q : 8'bz;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (WaitStates 0 and 2), each on its own RAM model,
// checked against a byte-array reference model and latency/strobe rules.
`timescale 1ns/1ps
module tb_mem_bus_master;

    localparam int W0 = 0;
    localparam int W1 = 2;
`ifdef MEMBUS_WRITE_VERIFY_EN
    localparam bit         Verify    = 1'b1;
    localparam logic [7:0] StuckMask = 8'hFE;
`else
    localparam bit         Verify    = 1'b0;
    localparam logic [7:0] StuckMask = 8'hFF;
`endif

    logic             clk = 1'b0;
    logic             rst_;
    logic [1:0]       req, wr;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  wdata;
    wire  [1:0][7:0]  rdata;
    wire  [1:0]       ack, busy, err, cs_, oe_, we_;
    wire  [1:0][15:0] addr;
    wire  [7:0]       data0, data1;
    wire  [1:0]       drv;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [7:0] ram   [2][256];
    logic [7:0] model [2][256];
    logic [7:0] exp_rdata [2];

    always #5 clk = ~clk;

    mem_bus_master #(.WaitStates(W0), .CntWidth(4)) u_dut0 (
        .clk(clk), .rst_(rst_), .req(req[0]), .wr(wr[0]), .req_addr(req_addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]),
        .cs_(cs_[0]), .oe_(oe_[0]), .we_(we_[0]), .addr(addr[0]), .data(data0));

    mem_bus_master #(.WaitStates(W1), .CntWidth(4)) u_dut1 (
        .clk(clk), .rst_(rst_), .req(req[1]), .wr(wr[1]), .req_addr(req_addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]),
        .cs_(cs_[1]), .oe_(oe_[1]), .we_(we_[1]), .addr(addr[1]), .data(data1));

    assign drv = {u_dut1.wr_drive, u_dut0.wr_drive};

    // RAM 0 has data bit 0 stuck low on its read path when verify is built in.
    assign data0 = (!cs_[0] && !oe_[0]) ? (ram[0][addr[0][7:0]] & StuckMask) : 8'bz;
    assign data1 = (!cs_[1] && !oe_[1]) ? ram[1][addr[1][7:0]] : 8'bz;

    always @(posedge clk) begin
        if (!rst_) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 256; a++) ram[d][a] <= 8'h00;
        end else begin
            if (!cs_[0] && !we_[0]) ram[0][addr[0][7:0]] <= data0;
            if (!cs_[1] && !we_[1]) ram[1][addr[1][7:0]] <= data1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (drv[d] && !oe_[d]) begin
                    n_bad++;
                    $display("FAIL contention[%0d]: wr_drive=%b oe_=%b, required never both active",
                             d, drv[d], oe_[d]);
                end
                n_cmp++;
                if ($isunknown({cs_[d], oe_[d], we_[d]})) begin
                    n_bad++;
                    $display("FAIL strobe_x[%0d]: got %b, required no X", d, {cs_[d], oe_[d], we_[d]});
                end
            end
        end
    end

    function automatic int ws(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic logic [7:0] rmask(input int d);
        return (d == 0) ? StuckMask : 8'hFF;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) model[d][a] = 8'h00;
            exp_rdata[d] = 8'h00;
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [7:0] wd,
                        input bit pulse_extra, input bit chain, input bit nw,
                        input logic [15:0] na, input logic [7:0] nd, input string tag);
        int k, ack_k, n_cs, n_oe, n_we, exp_ack, exp_cs, exp_oe, exp_we, wsd;
        bit busy_ok, exp_err;
        logic [7:0] exp_rd;
        wsd     = ws(d);
        exp_ack = (w && Verify) ? 4 + 2 * wsd : 2 + wsd;
        exp_cs  = (w && Verify) ? 2 * (1 + wsd) : 1 + wsd;
        exp_oe  = (!w || Verify) ? 1 + wsd : 0;
        exp_we  = w ? 1 + wsd : 0;
        exp_rd  = w ? exp_rdata[d] : (model[d][a[7:0]] & rmask(d));
        exp_err = Verify && w && ((wd & rmask(d)) != wd);

        req[d] = 1'b1; wr[d] = w; req_addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req[d] = pulse_extra;
        if (pulse_extra) begin
            wr[d] = 1'b1; req_addr[d] = 16'h0004; wdata[d] = 8'h77;
        end
        n_cmp++;
        if (err[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s err_clear: got %b, expected 0", tag, err[d]);
        end

        k = 0; ack_k = -1; n_cs = 0; n_oe = 0; n_we = 0; busy_ok = 1'b1;
        while (ack_k < 0 && k <= 40) begin
            if (busy[d] !== 1'b1) busy_ok = 1'b0;
            if (cs_[d] === 1'b0) n_cs++;
            if (oe_[d] === 1'b0) n_oe++;
            if (we_[d] === 1'b0) n_we++;
            if (ack[d] === 1'b1) begin
                ack_k = k;
            end else begin
                if (pulse_extra && k == 1) req[d] = 1'b0;
                @(posedge clk);
                k++;
                @(negedge clk);
            end
        end
        if (chain) begin
            req[d] = 1'b1; wr[d] = nw; req_addr[d] = na; wdata[d] = nd;
        end

        n_cmp++;
        if (ack_k != exp_ack) begin
            n_bad++;
            $display("FAIL %s ack_edge: got %0d (-1 = none within bound), expected %0d", tag, ack_k, exp_ack);
        end
        n_cmp++;
        if (n_cs != exp_cs || n_oe != exp_oe || n_we != exp_we) begin
            n_bad++;
            $display("FAIL %s strobe_cycles cs/oe/we: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     tag, n_cs, n_oe, n_we, exp_cs, exp_oe, exp_we);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_bad++;
            $display("FAIL %s busy_continuous: got a low cycle, expected high until ack", tag);
        end
        n_cmp++;
        if (rdata[d] !== exp_rd) begin
            n_bad++;
            $display("FAIL %s rdata: got %h, expected %h", tag, rdata[d], exp_rd);
        end
        n_cmp++;
        if (err[d] !== exp_err) begin
            n_bad++;
            $display("FAIL %s err: got %b, expected %b", tag, err[d], exp_err);
        end

        if (w) model[d][a[7:0]] = wd;
        else   exp_rdata[d] = exp_rd;

        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ack[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after_ack ack/busy: got %b/%b, expected 0/0", tag, ack[d], busy[d]);
        end
        if (pulse_extra) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                n_cmp++;
                if (ack[d] !== 1'b0 || busy[d] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s ignored_req ack/busy: got %b/%b, expected 0/0", tag, ack[d], busy[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [30:0] got;
        rst_ = 1'b0; req = '0; wr = '0; req_addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            got = {cs_[d], oe_[d], we_[d], ack[d], busy[d], err[d], drv[d], addr[d], rdata[d]};
            n_cmp++;
            if (got !== {7'b1110000, 16'h0000, 8'h00}) begin
                n_bad++;
                $display("FAIL reset[%0d] {cs,oe,we,ack,busy,err,drv,addr,rdata}: got %h, expected %h",
                         d, got, {7'b1110000, 16'h0000, 8'h00});
            end
        end
        rst_ = 1'b1;
        clear_model();
        mon_en = 1'b1;
    endtask

    task automatic test_basic_w0();
        xfer(0, 1'b1, 16'h0002, 8'hAA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "w0_write");
        xfer(0, 1'b0, 16'h0002, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "w0_read");
    endtask

    task automatic test_basic_w2();
        xfer(1, 1'b1, 16'h0001, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "w2_write");
        xfer(1, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "w2_read");
    endtask

    task automatic test_write_verify();
        xfer(0, 1'b1, 16'h0010, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "verify_55");
        xfer(0, 1'b1, 16'h0011, 8'hAA, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "verify_aa");
    endtask

    task automatic test_ignore_req();
        xfer(1, 1'b1, 16'h0003, 8'h11, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, "busy_req_write");
        xfer(1, 1'b0, 16'h0004, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "busy_req_rd4");
        xfer(1, 1'b0, 16'h0003, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "busy_req_rd3");
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 16'h0020, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, "b2b_write");
            xfer(d, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0021, 8'hC3, "b2b_read");
            xfer(d, 1'b1, 16'h0021, 8'hC3, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, "b2b_write2");
        end
    endtask

    task automatic test_reset_abort();
        req[1] = 1'b1; wr[1] = 1'b1; req_addr[1] = 16'h0000; wdata[1] = 8'h99;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cs_[1] !== 1'b0 || we_[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_access cs/we: got %b/%b, expected 0/0", cs_[1], we_[1]);
        end
        rst_ = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cs_[1], we_[1], drv[1], busy[1], ack[1]} !== 5'b11000) begin
            n_bad++;
            $display("FAIL abort_reset {cs,we,drv,busy,ack}: got %b, expected 11000",
                     {cs_[1], we_[1], drv[1], busy[1], ack[1]});
        end
        rst_ = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (ack[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_no_ack: got %b, expected 0", ack[1]);
            end
        end
        xfer(1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "abort_read0");
    endtask

    task automatic test_random();
        int d, gap;
        bit w;
        logic [15:0] a;
        logic [7:0] wd;
        for (int i = 0; i < 40; i++) begin
            d   = int'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            a   = 16'($urandom_range(0, 31));
            wd  = 8'($urandom);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            xfer(d, w, a, wd, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_w0();
        test_basic_w2();
        test_write_verify();
        test_ignore_req();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
